// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// default timeout and the access legality check.
package load_store_unit_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int unsigned LSU_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_e;

    function automatic logic lsu_illegal(input logic       rd,
                                         input logic       wr,
                                         input logic [2:0] f3,
                                         input logic [1:0] a);
        logic bad;
        bad = rd & wr;
        case (f3)
            3'b000:  bad = bad;
            3'b001:  bad = bad | a[0];
            3'b010:  bad = bad | (a != 2'b00);
            3'b100:  bad = bad | wr;
            3'b101:  bad = bad | wr | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-lane replication/strobes and
// load lane extraction with sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int unsigned REGWIDTH = 32
) (
    input  logic [2:0]          funct3_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [REGWIDTH-1:0] store_data_i,
    input  logic [REGWIDTH-1:0] rdata_i,
    output logic [REGWIDTH-1:0] wdata_o,
    output logic [3:0]          wstrb_o,
    output logic [REGWIDTH-1:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wdata_o = store_data_i;
        wstrb_o = 4'hF;
        case (funct3_i)
            SB: begin
                wdata_o = {4{store_data_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            SH: begin
                wdata_o = {2{store_data_i[15:0]}};
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = rdata_i;
        case (funct3_i)
            LB:      load_data_o = {{(REGWIDTH-8){byte_sel[7]}}, byte_sel};
            LH:      load_data_o = {{(REGWIDTH-16){half_sel[15]}}, half_sel};
            LBU:     load_data_o = {{(REGWIDTH-8){1'b0}}, byte_sel};
            LHU:     load_data_o = {{(REGWIDTH-16){1'b0}}, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store stage: accepts one access, holds the pipeline while the
// word-wide memory port completes it, and reports misaligned/illegal/timeouts.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned REGWIDTH = 32,
    parameter int unsigned TIMEOUT  = LSU_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [2:0]          funct3,
    input  logic [REGWIDTH-1:0] ALUResult,
    input  logic [REGWIDTH-1:0] ReadData2,
    output logic                mem_req,
    output logic                mem_we,
    output logic [REGWIDTH-1:0] mem_addr,
    output logic [REGWIDTH-1:0] mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_ready,
    input  logic [REGWIDTH-1:0] mem_rdata,
    output logic [REGWIDTH-1:0] LoadData,
    output logic                done,
    output logic                fault,
    output logic                stall
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e          state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [REGWIDTH-1:0] addr_q, addr_d;
    logic [REGWIDTH-1:0] rs2_q, rs2_d;
    logic [REGWIDTH-1:0] ld_q, ld_d;
    logic                fault_q, fault_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;

    logic                access;
    logic                illegal;
    logic [REGWIDTH-1:0] wdata;
    logic [REGWIDTH-1:0] ext;
    logic [3:0]          wstrb;

    assign access  = req_valid & (MemRead | MemWrite);
    assign illegal = lsu_illegal(MemRead, MemWrite, funct3, ALUResult[1:0]);
    assign cnt_inc = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;

    lsu_align #(
        .REGWIDTH (REGWIDTH)
    ) u_align (
        .funct3_i     (f3_q),
        .addr_lo_i    (addr_q[1:0]),
        .store_data_i (rs2_q),
        .rdata_i      (mem_rdata),
        .wdata_o      (wdata),
        .wstrb_o      (wstrb),
        .load_data_o  (ext)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        rs2_d   = rs2_q;
        ld_d    = ld_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        mem_req = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        fault   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (illegal) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        if (MemRead) ld_d = '0;
                    end else begin
                        state_d = BUSY;
                        fault_d = 1'b0;
                        we_d    = MemWrite;
                        f3_d    = funct3;
                        addr_d  = ALUResult;
                        rs2_d   = ReadData2;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                cnt_d   = cnt_inc;
                if (mem_ready) begin
                    state_d = DONE;
                    if (!we_q) ld_d = ext;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    // TIMEOUT request cycles have elapsed with no response
                    state_d = DONE;
                    fault_d = 1'b1;
                    if (!we_q) ld_d = '0;
                end
            end
            DONE: begin
                done    = 1'b1;
                fault   = fault_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            rs2_q   <= '0;
            ld_q    <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            rs2_q   <= rs2_d;
            ld_q    <= ld_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[REGWIDTH-1:2], 2'b00};
    assign mem_wdata = wdata;
    assign mem_wstrb = we_q ? wstrb : 4'b0000;
    assign LoadData  = ld_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout to reach the
// fault path quickly.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] ReadData2;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] LoadData;
    logic        done;
    logic        fault;
    logic        stall;

    int unsigned checks = 0;
    int unsigned errors = 0;

    load_store_unit #(
        .REGWIDTH (32),
        .TIMEOUT  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .ALUResult (ALUResult),
        .ReadData2 (ReadData2),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .LoadData  (LoadData),
        .done      (done),
        .fault     (fault),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one access at posedge+1, responds after 'lat' refused request
    // cycles, and records what the DUT showed; returns at posedge+1 in IDLE.
    task automatic do_access(input  logic        re,
                             input  logic        we,
                             input  logic [2:0]  f3,
                             input  logic [31:0] addr,
                             input  logic [31:0] rs2,
                             input  logic [31:0] rdata,
                             input  int unsigned lat,
                             output int unsigned stall_cnt,
                             output int unsigned req_cnt,
                             output int unsigned done_at,
                             output logic        flt,
                             output logic [31:0] ld,
                             output logic [31:0] o_addr,
                             output logic [31:0] o_wdata,
                             output logic [3:0]  o_wstrb,
                             output logic        o_we);
        stall_cnt = 0;
        req_cnt   = 0;
        done_at   = 999;
        flt       = 1'b0;
        ld        = '0;
        o_addr    = '0;
        o_wdata   = '0;
        o_wstrb   = '0;
        o_we      = 1'b0;
        req_valid = 1'b1;
        MemRead   = re;
        MemWrite  = we;
        funct3    = f3;
        ALUResult = addr;
        ReadData2 = rs2;
        mem_rdata = rdata;
        mem_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                o_addr  = mem_addr;
                o_wdata = mem_wdata;
                o_wstrb = mem_wstrb;
                o_we    = mem_we;
            end
            if (done) begin
                done_at = i;
                flt     = fault;
                ld      = LoadData;
                break;
            end
            mem_ready = mem_req && (req_cnt > lat);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_req, mem_we, mem_wstrb, done, fault, stall} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000000",
                     {mem_req, mem_we, mem_wstrb, done, fault, stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, LoadData} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h ld=%h exp all zero",
                     mem_addr, mem_wdata, LoadData);
        end
    endtask

    task automatic test_sw();
        int unsigned sc, rc, da;
        logic f, w;
        logic [31:0] ld, a, wd;
        logic [3:0] st;
        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (a !== 32'h100) begin errors++; $display("FAIL sw_addr got %h exp 00000100", a); end
        checks++;
        if (st !== 4'hF) begin errors++; $display("FAIL sw_wstrb got %h exp f", st); end
        checks++;
        if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", wd); end
        checks++;
        if (w !== 1'b1) begin errors++; $display("FAIL sw_we got %b exp 1", w); end
        checks++;
        if (da !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", da); end
        checks++;
        if (sc !== 2) begin errors++; $display("FAIL sw_stall_cycles got %0d exp 2", sc); end
        checks++;
        if (rc !== 1) begin errors++; $display("FAIL sw_req_cycles got %0d exp 1", rc); end
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL sw_fault got %b exp 0", f); end
        checks++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL sw_done_pulse got done=%b stall=%b exp 0 0", done, stall);
        end
    endtask

    task automatic test_sb_sh();
        int unsigned sc, rc, da;
        logic f, w;
        logic [31:0] ld, a, wd;
        logic [3:0] st;
        do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (st !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got %b exp 1000", st); end
        checks++;
        if (wd !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", wd); end
        checks++;
        if (a !== 32'h100) begin errors++; $display("FAIL sb_addr got %h exp 00000100", a); end
        do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 2,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (st !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b exp 1100", st); end
        checks++;
        if (wd !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", wd); end
        checks++;
        if (da !== 4 || sc !== 4) begin
            errors++;
            $display("FAIL sh_wait_latency got done_at=%0d stall=%0d exp 4 4", da, sc);
        end
    endtask

    task automatic test_loads();
        int unsigned sc, rc, da;
        logic f, w;
        logic [31:0] ld, a, wd;
        logic [3:0] st;
        do_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h12348000, 0,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", ld); end
        checks++;
        if (st !== 4'b0000 || w !== 1'b0) begin
            errors++;
            $display("FAIL lb_rd_strobe got wstrb=%b we=%b exp 0000 0", st, w);
        end
        checks++;
        if (a !== 32'h100) begin errors++; $display("FAIL lb_addr got %h exp 00000100", a); end
        do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h11111111, 32'h0, 0,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (LoadData !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL store_keeps_ld got %h exp ffffff80", LoadData);
        end
        do_access(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h12348000, 0,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (ld !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", ld); end
        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001FFFF, 0,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (ld !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", ld); end
        checks++;
        if (LoadData !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh_hold got %h exp ffff8001", LoadData);
        end
    endtask

    task automatic test_misaligned();
        int unsigned sc, rc, da;
        logic f, w;
        logic [31:0] ld, a, wd;
        logic [3:0] st;
        do_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hFFFFFFFF, 0,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (rc !== 0) begin errors++; $display("FAIL mis_no_req got %0d exp 0", rc); end
        checks++;
        if (da !== 1 || f !== 1'b1) begin
            errors++;
            $display("FAIL mis_fault got done_at=%0d fault=%b exp 1 1", da, f);
        end
        checks++;
        if (ld !== 32'h0) begin errors++; $display("FAIL mis_ld got %h exp 00000000", ld); end
        checks++;
        if (sc !== 1) begin errors++; $display("FAIL mis_stall got %0d exp 1", sc); end
        do_access(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 0,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (rc !== 0 || da !== 1 || f !== 1'b1) begin
            errors++;
            $display("FAIL bad_store_f3 got req=%0d done_at=%0d fault=%b exp 0 1 1", rc, da, f);
        end
    endtask

    task automatic test_timeout();
        int unsigned sc, rc, da;
        logic f, w;
        logic [31:0] ld, a, wd;
        logic [3:0] st;
        do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D, 0,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (ld !== 32'h0BADF00D) begin errors++; $display("FAIL lw_data got %h exp 0badf00d", ld); end
        do_access(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 32'h55555555, 100,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (rc !== 4) begin errors++; $display("FAIL to_req_cycles got %0d exp 4", rc); end
        checks++;
        if (da !== 5 || f !== 1'b1) begin
            errors++;
            $display("FAIL to_fault got done_at=%0d fault=%b exp 5 1", da, f);
        end
        checks++;
        if (ld !== 32'h0) begin errors++; $display("FAIL to_ld got %h exp 00000000", ld); end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (done !== 1'b0 || mem_req !== 1'b0 || LoadData !== 32'h0) begin
                errors++;
                $display("FAIL late_ready got done=%b req=%b ld=%h exp 0 0 00000000",
                         done, mem_req, LoadData);
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int unsigned sc, rc, da;
        logic f, w;
        logic [31:0] ld, a, wd;
        logic [3:0] st;
        req_valid = 1'b1;
        MemRead   = 1'b1;
        funct3    = 3'b010;
        ALUResult = 32'h200;
        mem_rdata = 32'h77777777;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b exp 1", mem_req); end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %b exp 0", mem_req); end
        req_valid = 1'b0;
        MemRead   = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || stall !== 1'b0 || LoadData !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_idle got done=%b stall=%b ld=%h exp 0 0 00000000",
                     done, stall, LoadData);
        end
        mem_ready = 1'b0;
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 1,
                  sc, rc, da, f, ld, a, wd, st, w);
        checks++;
        if (ld !== 32'hCAFEF00D || f !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_lw got ld=%h fault=%b exp cafef00d 0", ld, f);
        end
        checks++;
        if (da !== 3 || a !== 32'h10) begin
            errors++;
            $display("FAIL rst_after_lw_timing got done_at=%0d addr=%h exp 3 00000010", da, a);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        funct3    = 3'b000;
        ALUResult = '0;
        ReadData2 = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        #2;
        test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_sw();
        test_sb_sh();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
